// File: rtl/loop_player.sv
// Loop player: replays a dual-clock sample buffer from address 0 to a latched last
// address, for a latched number of passes (0 = forever), with hold/stop/restart control.
module loop_player #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              r_clk,
  input  logic              r_reset_n,
  input  logic              r_start,
  input  logic              r_stop,
  input  logic              r_hold,
  input  logic [ADDR_W-1:0] r_last,
  input  logic [CNT_W-1:0]  r_loops,
  output logic [DATA_W-1:0] r_out,
  output logic              r_valid,
  output logic              r_wrap,
  output logic              r_busy,
  output logic              r_done,
  input  logic              w_clk,
  input  logic              w_enable,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_in
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  logic [DATA_W-1:0] r_mem [DEPTH];

  state_t            r_state;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [CNT_W-1:0]  r_pass;
  logic [ADDR_W-1:0] r_last_lat;

  state_t            w_state_nxt;
  logic [ADDR_W-1:0] w_rd_addr_nxt;
  logic [CNT_W-1:0]  w_pass_nxt;
  logic [ADDR_W-1:0] w_last_nxt;
  logic              w_load;
  logic              w_wrap_nxt;

  // Write port: no reset, contents survive read-side reset
  always_ff @(posedge w_clk) begin
    if (w_enable) begin
      r_mem[w_addr] <= w_in;
    end
  end

  // Next-state: stop beats start beats hold beats advance
  always_comb begin
    w_state_nxt   = r_state;
    w_rd_addr_nxt = r_rd_addr;
    w_pass_nxt    = r_pass;
    w_last_nxt    = r_last_lat;
    w_load        = 1'b0;
    w_wrap_nxt    = 1'b0;
    if (r_stop) begin
      w_state_nxt = S_IDLE;
    end else if (r_start) begin
      w_state_nxt   = S_PLAY;
      w_rd_addr_nxt = '0;
      w_pass_nxt    = r_loops;
      w_last_nxt    = r_last;
    end else if (r_state == S_PLAY && !r_hold) begin
      w_load = 1'b1;
      if (r_rd_addr == r_last_lat) begin
        // End of pass; a latched count of 0 never reaches 1, so it loops forever
        w_wrap_nxt    = 1'b1;
        w_rd_addr_nxt = '0;
        if (r_pass == CNT_W'(1)) begin
          w_state_nxt = S_DONE;
        end else if (r_pass != '0) begin
          w_pass_nxt = r_pass - CNT_W'(1);
        end
      end else begin
        w_rd_addr_nxt = r_rd_addr + ADDR_W'(1);
      end
    end
  end

  // State and output registers
  always_ff @(posedge r_clk) begin
    if (!r_reset_n) begin
      r_state    <= S_IDLE;
      r_rd_addr  <= '0;
      r_pass     <= '0;
      r_last_lat <= '0;
      r_out      <= '0;
      r_valid    <= 1'b0;
      r_wrap     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rd_addr  <= w_rd_addr_nxt;
      r_pass     <= w_pass_nxt;
      r_last_lat <= w_last_nxt;
      if (w_load) begin
        r_out <= r_mem[r_rd_addr];
      end
      r_valid    <= w_load;
      r_wrap     <= w_wrap_nxt;
      r_busy     <= (w_state_nxt == S_PLAY);
      r_done     <= (w_state_nxt == S_DONE);
    end
  end

endmodule

// File: tb/tb_loop_player.sv
// Directed bench for loop_player: buffer preloaded with i+100, playback sequences
// checked against hand-computed values after each read-clock edge.
module tb_loop_player;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned CNT_W  = 8;

  logic              r_clk = 1'b0;
  logic              w_clk = 1'b0;
  logic              r_reset_n = 1'b0;
  logic              r_start = 1'b0;
  logic              r_stop = 1'b0;
  logic              r_hold = 1'b0;
  logic [ADDR_W-1:0] r_last = '0;
  logic [CNT_W-1:0]  r_loops = '0;
  logic [DATA_W-1:0] r_out;
  logic              r_valid, r_wrap, r_busy, r_done;
  logic              w_enable = 1'b0;
  logic [ADDR_W-1:0] w_addr = '0;
  logic [DATA_W-1:0] w_in = '0;

  int vectors = 0;
  int errors  = 0;

  loop_player #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .r_clk(r_clk), .r_reset_n(r_reset_n), .r_start(r_start), .r_stop(r_stop),
    .r_hold(r_hold), .r_last(r_last), .r_loops(r_loops), .r_out(r_out),
    .r_valid(r_valid), .r_wrap(r_wrap), .r_busy(r_busy), .r_done(r_done),
    .w_clk(w_clk), .w_enable(w_enable), .w_addr(w_addr), .w_in(w_in)
  );

  always #5 r_clk = ~r_clk;
  always #7 w_clk = ~w_clk;

  task automatic tick();
    @(posedge r_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] out, input logic valid,
                         input logic wrap, input logic busy, input logic done);
    chk({tag, ".out"},   r_out,   out);
    chk({tag, ".valid"}, 32'(r_valid), 32'(valid));
    chk({tag, ".wrap"},  32'(r_wrap),  32'(wrap));
    chk({tag, ".busy"},  32'(r_busy),  32'(busy));
    chk({tag, ".done"},  32'(r_done),  32'(done));
  endtask

  task automatic wr(input int a, input int d);
    @(posedge w_clk);
    #1;
    w_enable = 1'b1;
    w_addr   = ADDR_W'(a);
    w_in     = DATA_W'(d);
    @(posedge w_clk);
    #1;
    w_enable = 1'b0;
  endtask

  task automatic start(input int last, input int loops);
    r_start = 1'b1;
    r_last  = ADDR_W'(last);
    r_loops = CNT_W'(loops);
    tick();
    r_start = 1'b0;
  endtask

  initial begin
    // Reset with buffer loading in parallel
    for (int i = 0; i < 16; i++) wr(i, i + 100);
    tick();
    chk_all("reset", 0, 0, 0, 0, 0);
    r_reset_n = 1'b1;
    tick();
    chk_all("idle", 0, 0, 0, 0, 0);

    // Single pass over 0..3
    start(3, 1);
    chk("p1.start_valid", 32'(r_valid), 0);
    chk("p1.start_busy", 32'(r_busy), 1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk_all($sformatf("p1.s%0d", k), 99 + k, 1, k == 4, k != 4, k == 4);
    end
    tick();
    chk_all("p1.after", 103, 0, 0, 0, 1);

    // Three passes over 0..1
    start(1, 3);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk_all($sformatf("p3.s%0d", k), 100 + ((k - 1) % 2), 1, (k % 2) == 0, k != 6, k == 6);
    end
    tick();
    chk_all("p3.after", 101, 0, 0, 0, 1);

    // Infinite loop over 0..2; changes to last/loops mid-play are ignored
    start(2, 0);
    r_last  = ADDR_W'(0);
    r_loops = CNT_W'(1);
    for (int k = 1; k <= 21; k++) begin
      tick();
      chk_all($sformatf("inf.s%0d", k), 100 + ((k - 1) % 3), 1, (k % 3) == 0, 1, 0);
    end
    r_stop = 1'b1;
    tick();
    r_stop = 1'b0;
    chk_all("inf.stop", 102, 0, 0, 0, 0);

    // Hold for three cycles after sample 101
    start(3, 1);
    tick();
    chk("hold.s1", r_out, 100);
    tick();
    chk("hold.s2", r_out, 101);
    r_hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_all($sformatf("hold.h%0d", k), 101, 0, 0, 1, 0);
    end
    r_hold = 1'b0;
    tick();
    chk_all("hold.resume", 102, 1, 0, 1, 0);

    // Restart during play at sample 102 with new last/loops
    start(1, 1);
    chk("restart.valid", 32'(r_valid), 0);
    chk("restart.busy", 32'(r_busy), 1);
    tick();
    chk_all("restart.s1", 100, 1, 0, 1, 0);
    tick();
    chk_all("restart.s2", 101, 1, 1, 0, 1);

    // Stop beats start; start beats hold
    start(3, 0);
    tick();
    chk("prio.s1", r_out, 100);
    r_start = 1'b1;
    r_stop  = 1'b1;
    tick();
    r_start = 1'b0;
    r_stop  = 1'b0;
    chk_all("prio.stop_start", 100, 0, 0, 0, 0);
    r_hold = 1'b1;
    start(1, 1);
    chk_all("prio.start_hold", 100, 0, 0, 1, 0);
    tick();
    chk_all("prio.held", 100, 0, 0, 1, 0);
    r_hold = 1'b0;
    tick();
    chk_all("prio.released", 100, 1, 0, 1, 0);

    // Reset mid-play, stays idle, memory intact
    start(3, 0);
    tick();
    tick();
    chk("rst.s2", r_out, 101);
    r_reset_n = 1'b0;
    tick();
    r_reset_n = 1'b1;
    chk_all("rst.pulse", 0, 0, 0, 0, 0);
    tick();
    tick();
    chk_all("rst.idle", 0, 0, 0, 0, 0);
    start(3, 1);
    tick();
    chk_all("rst.s1", 100, 1, 0, 1, 0);
    tick();
    chk_all("rst.s2b", 101, 1, 0, 1, 0);

    // Full-depth last address wraps to 0
    start(15, 2);
    for (int k = 1; k <= 17; k++) begin
      tick();
      chk_all($sformatf("full.s%0d", k), 100 + ((k - 1) % 16), 1, k == 16, 1, 0);
    end
    r_stop = 1'b1;
    tick();
    r_stop = 1'b0;

    // last=0 replays mem[0] once per pass
    start(0, 2);
    tick();
    chk_all("zero.s1", 100, 1, 1, 1, 0);
    tick();
    chk_all("zero.s2", 100, 1, 1, 0, 1);
    tick();
    chk_all("zero.after", 100, 0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/loop_player.md
LOOP_PLAYER -- requirements
Module: loop_player

Interface
REQ-001 Parameter DATA_W, default 32, sample width in bits.
REQ-002 Parameter ADDR_W, default 10, buffer depth is 2**ADDR_W words.
REQ-003 Parameter CNT_W, default 8, width of the pass counter.
REQ-004 r_clk  in  1  read-side clock; all r_* logic runs on it.
REQ-005 r_reset_n  in  1  read-side reset, synchronous, active-low.
REQ-006 r_start  in  1  pulse: latch r_last and r_loops, begin playback at address 0.
REQ-007 r_stop  in  1  abort playback, return to IDLE.
REQ-008 r_hold  in  1  pause; address and r_out frozen while high.
REQ-009 r_last  in  ADDR_W  last address played in each pass (inclusive); sampled on r_start only.
REQ-010 r_loops  in  CNT_W  number of passes; 0 = loop forever; sampled on r_start only.
REQ-011 r_out  out  DATA_W  current sample (registered).
REQ-012 r_valid  out  1  r_out was updated this cycle with a new sample.
REQ-013 r_wrap  out  1  one-cycle pulse, coincident with r_out = mem[last] of any pass.
REQ-014 r_busy  out  1  high in PLAY state.
REQ-015 r_done  out  1  high in DONE state.
REQ-016 w_clk  in  1  write-side clock, asynchronous to r_clk.
REQ-017 w_enable  in  1  write strobe.
REQ-018 w_addr  in  ADDR_W  write address.
REQ-019 w_in  in  DATA_W  write data; mem[w_addr] <= w_in on w_clk edge when w_enable=1.

Function
REQ-020 The state machine SHALL have the states IDLE, PLAY and DONE; r_busy = (PLAY), r_done = (DONE).
REQ-021 Per-edge priority SHALL be: reset > r_stop > r_start > r_hold > normal advance.
REQ-022 r_stop in any state SHALL go to IDLE with r_valid=0 and r_wrap=0; r_out holds its value.
REQ-023 r_start in any state, including PLAY, SHALL go to PLAY with addr=0, pass count=r_loops and last=r_last latched; r_valid=0 on that edge.
REQ-024 In PLAY with r_hold=0, each edge SHALL set r_out<=mem[addr], r_valid<=1 and addr<=addr+1; first sample mem[0] appears on the edge after r_start (latency 1).
REQ-025 In PLAY with r_hold=1, r_valid SHALL be 0, and addr, r_out and the pass count SHALL hold.
REQ-026 When addr==last on an advancing edge, r_wrap<=1 and addr<=0; if the pass count is 1, go to DONE, else decrement it (no decrement when latched r_loops=0).
REQ-027 last = 2**ADDR_W-1 SHALL wrap addr to 0 without an extra address bit; last=0 SHALL replay mem[0] once per pass.
REQ-028 In IDLE and DONE, r_valid and r_wrap SHALL be 0 and r_out SHALL hold.
REQ-029 Changes to r_last and r_loops during PLAY SHALL have no effect until the next r_start.
REQ-030 A read of an address written in the same interval is a don't-care (old or new data); no other cross-clock interaction exists.

Reset
REQ-031 On r_clk edge with r_reset_n=0: state=IDLE, addr=0, r_out=0, r_valid=0, r_wrap=0, r_busy=0, r_done=0, pass count=0.
REQ-032 Reset SHALL NOT clear memory contents; w_clk side SHALL have no reset.
REQ-033 Reset mid-PLAY SHALL abort immediately, and playback SHALL stay in IDLE after release until r_start.

Verification
REQ-034 mem[i]=i+100 for i=0..3, start with last=3, loops=1 -> r_out 100,101,102,103 on edges 1..4, r_wrap on edge 4, r_done=1 from edge 4.
REQ-035 last=1, loops=3 -> r_out sequence 100,101,100,101,100,101; r_wrap three times; DONE after sixth sample.
REQ-036 loops=0, last=2 -> 100,101,102 repeating for 20+ cycles; r_done stays 0; then r_stop -> IDLE, r_valid=0.
REQ-037 r_hold high for 3 cycles after sample 101 -> r_valid=0 and r_out=101 for 3 cycles, then 102 next.
REQ-038 r_start asserted during PLAY at sample 102 -> next valid sample is 100 with the newly latched r_last/r_loops.
REQ-039 r_reset_n low for 1 cycle mid-PLAY -> all outputs 0 on the next edge; stays IDLE; memory still reads 100.. after new r_start.
